mc_cmd_ramp: RTL and testbench

MC_CMD_RAMP -- requirements
Module: mc_cmd_ramp

---
 rtl/mc_pkg.sv | 16 +
 rtl/ramp_step.sv | 26 ++
 rtl/mc_cmd_ramp.sv | 120 ++++++++++++
 tb/tb_mc_cmd_ramp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the motor-command ramp: code width, stop code and FSM state encoding.
package mc_pkg;

  localparam int unsigned CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t MC_NEUTRAL = 5'd16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ESTOP   = 2'd2
  } state_e;

endpackage

// File: rtl/ramp_step.sv
// One channel's slew step: move current toward target by at most step, landing exactly on target.
module ramp_step
  import mc_pkg::*;
(
  input  logic [CODE_W-1:0] current,
  input  logic [CODE_W-1:0] target,
  input  logic [CODE_W-1:0] step,
  output logic [CODE_W-1:0] next
);

  logic [CODE_W-1:0] diff;

  always_comb begin
    next = current;
    diff = '0;
    // Both sums stay between current and target, so the 5-bit range can never be left.
    if (target > current) begin
      diff = target - current;
      next = (diff > step) ? current + step : target;
    end else if (target < current) begin
      diff = current - target;
      next = (diff > step) ? current - step : target;
    end
  end

endmodule

// File: rtl/mc_cmd_ramp.sv
// Frame-paced slew limiter for two motor-controller codes, with command timeout and emergency stop.
module mc_cmd_ramp
  import mc_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES   = 1100000,
  parameter code_t       STEP           = 5'd1,
  parameter code_t       NEUTRAL        = MC_NEUTRAL,
  parameter logic [5:0]  TIMEOUT_FRAMES = 6'd45
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_mc1,
  input  logic [4:0] cmd_mc2,
  input  logic       estop,
  output logic [4:0] MC1,
  output logic [4:0] MC2,
  output logic       frame_tick,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       sil_q, sil_d;
  code_t            tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  code_t            mc1_q, mc1_d, mc2_q, mc2_d;
  state_e           state_q, state_d;
  code_t            step1_next, step2_next;
  logic             tick, accept;

  assign tick       = (cnt_q == CNT_LAST);
  assign cmd_ready  = (state_q != ST_ESTOP);
  assign accept     = cmd_valid && cmd_ready;
  assign frame_tick = tick;
  assign MC1        = mc1_q;
  assign MC2        = mc2_q;
  assign state_o    = state_q;

  ramp_step u_step1 (.current(mc1_q), .target(tgt1_q), .step(STEP), .next(step1_next));
  ramp_step u_step2 (.current(mc2_q), .target(tgt2_q), .step(STEP), .next(step2_next));

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    sil_d   = sil_q;
    tgt1_d  = tgt1_q;
    tgt2_d  = tgt2_q;
    mc1_d   = mc1_q;
    mc2_d   = mc2_q;
    state_d = state_q;

    if (tick && (sil_q < TIMEOUT_FRAMES)) sil_d = sil_q + 1'b1;
    if (accept) begin
      sil_d  = '0;
      tgt1_d = cmd_mc1;
      tgt2_d = cmd_mc2;
    end

    // Step uses the registered target, so a command landing on a tick takes effect one frame later.
    if (tick && (state_q != ST_ESTOP)) begin
      mc1_d = step1_next;
      mc2_d = step2_next;
    end

    case (state_q)
      ST_RUN: begin
        if (sil_d == TIMEOUT_FRAMES) begin
          state_d = ST_TIMEOUT;
          tgt1_d  = NEUTRAL;
          tgt2_d  = NEUTRAL;
        end
      end
      ST_TIMEOUT: begin
        if (accept) state_d = ST_RUN;
      end
      ST_ESTOP: begin
        mc1_d  = NEUTRAL;
        mc2_d  = NEUTRAL;
        tgt1_d = NEUTRAL;
        tgt2_d = NEUTRAL;
        if (!estop) begin
          state_d = ST_TIMEOUT;
          sil_d   = '0;
        end
      end
      default: state_d = ST_TIMEOUT;
    endcase

    if (estop) begin
      state_d = ST_ESTOP;
      mc1_d   = NEUTRAL;
      mc2_d   = NEUTRAL;
      tgt1_d  = NEUTRAL;
      tgt2_d  = NEUTRAL;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      sil_q   <= '0;
      tgt1_q  <= NEUTRAL;
      tgt2_q  <= NEUTRAL;
      mc1_q   <= NEUTRAL;
      mc2_q   <= NEUTRAL;
      state_q <= ST_TIMEOUT;
    end else begin
      cnt_q   <= cnt_d;
      sil_q   <= sil_d;
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      mc1_q   <= mc1_d;
      mc2_q   <= mc2_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mc_cmd_ramp.sv
// Scoreboard bench for mc_cmd_ramp: expected codes per frame tick are queued, a monitor compares them.
module tb_mc_cmd_ramp;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_mc1, cmd_mc2;
  logic       estop;
  logic [4:0] MC1, MC2;
  logic       frame_tick;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mc1;
    int mc2;
    int st;
  } exp_t;

  exp_t expq[$];

  always #5 CLK = ~CLK;

  mc_cmd_ramp #(
    .FRAME_CYCLES  (100),
    .STEP          (5'd2),
    .NEUTRAL       (5'd16),
    .TIMEOUT_FRAMES(6'd4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mc1   (cmd_mc1),
    .cmd_mc2   (cmd_mc2),
    .estop     (estop),
    .MC1       (MC1),
    .MC2       (MC2),
    .frame_tick(frame_tick),
    .state_o   (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_tick(input int a, input int b, input int s);
    exp_t t;
    t.mc1 = a;
    t.mc2 = b;
    t.st  = s;
    expq.push_back(t);
  endtask

  // Returns at the negedge inside the tick cycle (before the tick edge).
  task automatic wait_tick_cycle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_tick && n < 300);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no frame_tick within %0d cycles expected one", n);
    end
  endtask

  // Returns at the negedge after the tick edge has been applied.
  task automatic wait_tick();
    wait_tick_cycle();
    @(negedge CLK);
  endtask

  task automatic send(input int c1, input int c2);
    cmd_valid = 1'b1;
    cmd_mc1   = 5'(c1);
    cmd_mc2   = 5'(c2);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (frame_tick && !RST) begin
        @(negedge CLK);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got tick with MC1=%0d MC2=%0d expected no tick", MC1, MC2);
        end else begin
          e = expq.pop_front();
          chk("tick_mc1", MC1, e.mc1);
          chk("tick_mc2", MC2, e.mc2);
          chk("tick_state", state_o, e.st);
        end
      end
    end
  end

  initial begin : stim
    int r1[8];
    int r2[8];
    int n;
    r1 = '{18, 20, 22, 24, 26, 28, 30, 30};
    r2 = '{14, 12, 10, 8, 6, 4, 2, 2};

    RST = 1'b1; cmd_valid = 1'b0; estop = 1'b0; cmd_mc1 = '0; cmd_mc2 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_mc1", MC1, 16);
    chk("rst_mc2", MC2, 16);
    chk("rst_tick", frame_tick, 0);
    chk("rst_state", state_o, 1);
    chk("rst_ready", cmd_ready, 1);
    RST = 1'b0;

    // Ramp out to (30,2) with a keep-alive command each frame.
    send(30, 2);
    for (int i = 0; i < 8; i++) begin
      expect_tick(r1[i], r2[i], 0);
      wait_tick();
      if (i < 7) send(30, 2);
    end

    // Odd distance must land on target, not overshoot.
    send(29, 2);
    expect_tick(29, 2, 0);
    wait_tick();
    send(30, 2);
    expect_tick(30, 2, 0);
    wait_tick();
    send(30, 2);

    // Silence: fourth tick enters TIMEOUT, then ramp back to neutral.
    expect_tick(30, 2, 0);
    expect_tick(30, 2, 0);
    expect_tick(30, 2, 0);
    expect_tick(30, 2, 1);
    for (int i = 0; i < 7; i++) expect_tick(28 - 2 * i, 4 + 2 * i, 1);
    for (int i = 0; i < 11; i++) wait_tick();

    // Estop pulse at MC1=28.
    send(28, 16);
    for (int i = 0; i < 6; i++) begin
      expect_tick(18 + 2 * i, 16, 0);
      wait_tick();
      send(28, 16);
    end
    estop = 1'b1;
    @(negedge CLK);
    chk("estop_mc1", MC1, 16);
    chk("estop_mc2", MC2, 16);
    chk("estop_ready", cmd_ready, 0);
    chk("estop_state", state_o, 2);
    estop = 1'b0;
    @(negedge CLK);
    chk("estop_rel_state", state_o, 1);
    chk("estop_rel_ready", cmd_ready, 1);

    // Estop held across a tick while a command is offered.
    estop = 1'b1;
    cmd_valid = 1'b1; cmd_mc1 = 5'd31; cmd_mc2 = 5'd31;
    expect_tick(16, 16, 2);
    wait_tick();
    estop = 1'b0;
    cmd_valid = 1'b0;
    expect_tick(16, 16, 1);
    wait_tick();

    // Accept coincident with a tick: that tick uses the old target.
    send(10, 10);
    expect_tick(14, 14, 0);
    wait_tick_cycle();
    cmd_valid = 1'b1; cmd_mc1 = 5'd20; cmd_mc2 = 5'd20;
    @(negedge CLK);
    cmd_valid = 1'b0;
    expect_tick(16, 16, 0);
    wait_tick();

    // Reset mid-frame at MC=24, then measure the first frame after release.
    send(24, 24);
    for (int i = 0; i < 4; i++) begin
      expect_tick(18 + 2 * i, 18 + 2 * i, 0);
      wait_tick();
      if (i < 3) send(24, 24);
    end
    repeat (50) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst_mc1", MC1, 16);
    chk("midrst_mc2", MC2, 16);
    chk("midrst_state", state_o, 1);
    chk("midrst_tick", frame_tick, 0);
    repeat (2) @(negedge CLK);
    expect_tick(16, 16, 1);
    RST = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_tick && n < 300);
    chk("first_tick_edges", n + 1, 100);

    repeat (5) @(negedge CLK);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
